mc_main_control: RTL
====================

Name: mc_main_control

Overview:
- Multicycle main control FSM for the 32-bit MIPS core.
- Sits directly upstream of the ALU control decoder and drives its ALUOp/ALUOpImmediate inputs.
- Also sequences PC, instruction register, memory, register-file and mux selects from the opcode, with a ready handshake to memory.
- Keeps a count of retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from IR.
- zero  in  1  ALU zero flag, for branch.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if zero.
- IorD  out  1  0=PC, 1=ALUOut as memory address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data: 1=MDR, 0=ALUOut.
- RegDst  out  1  write register: 1=rd, 0=rt.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  0=PC, 1=regA.
- ALUSrcB  out  2  00=regB, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector.
- ALUOp  out  2  00=add, 01=sub, 10=use funct, 11=use ALUOpImmediate.
- ALUOpImmediate  out  3  001 addi, 010 subi, 011 andi, 100 ori, 101 slti, 000 otherwise.
- state  out  4  current state, for debug.
- trap  out  1  illegal opcode (feature only, else tied 0).
- retired  out  COUNT_W  retired-instruction count.

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, subi 001001, andi 001100, ori 001101, slti 001010.
- All control outputs are Moore-decoded from state, except where stated, and are 0 unless listed.
- rst_n low forces state=FETCH(0), retired=0, all control outputs=0, independent of clk. Reset mid-instruction abandons it and does not count it.
- FETCH(0): MemRead, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite are asserted only in the cycle mem_ready=1 (Mealy). Go to DECODE when mem_ready=1, else hold.
- DECODE(1): ALUSrcB=11, ALUOp=00. Next state by opcode:
  - lw/sw -> MEMADR(2)
  - R -> EXEC(6)
  - beq -> BRANCH(8)
  - j -> JUMP(9)
  - immediate ops -> IEXEC(10)
  - other -> FETCH, not counted.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD(3) for lw, MEMWR(5) for sw.
- MEMRD(3): MemRead, IorD. Hold until mem_ready, then MEMWB(4).
- MEMWB(4): RegWrite, MemtoReg, RegDst=0. Go to FETCH.
- MEMWR(5): MemWrite, IorD. Hold until mem_ready, then FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RTYPE_WB(7).
- RTYPE_WB(7): RegWrite, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Go to FETCH.
- JUMP(9): PCWrite, PCSource=10. Go to FETCH.
- IEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=11. ALUOpImmediate is decoded from opcode (held stable while in IEXEC). Go to IWB(11).
- IWB(11): RegWrite, RegDst=0, MemtoReg=0. Go to FETCH.
- States 12-15 other than TRAP are unreachable. If entered, next state is FETCH with all outputs 0.
- Retired counter:
  - Increments by 1 on the clock edge leaving MEMWB, the edge leaving MEMWR with mem_ready=1, and the edges leaving RTYPE_WB, BRANCH, JUMP and IWB.
  - Wraps from all-ones to 0.
- Latencies with mem_ready always 1: lw 5 cycles; sw, R, immediate 4; beq, j 3.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP(12). TRAP asserts trap=1, PCWrite=1, PCSource=11 for one cycle, then goes to FETCH. TRAP is not counted in retired.
- Undefined: unknown opcode goes DECODE->FETCH as a no-op, and trap is constant 0.

Test Plan:
- Assert rst_n=0 mid-MEMRD -> state=0, retired=0, all controls 0 immediately. After release, FETCH with MemRead=1.
- lw (100011), mem_ready=1 always -> states 0,1,2,3,4,0. RegWrite=1, MemtoReg=1 in state 4. retired 0->1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles. Exit and count only on the ready cycle.
- ori (001101) -> in state 10, ALUOp=11 and ALUOpImmediate=100. R-type -> in state 6, ALUOp=10. beq -> in state 8, ALUOp=01 and PCWriteCond=1.
- Preload the counter to all-ones via 2^COUNT_W-1 retirements (COUNT_W=4 build: 15 j instructions), then one more j -> retired=0.
- Opcode 111111: with ILLEGAL_TRAP_EN -> state 12, trap=1, PCSource=11 for 1 cycle, retired unchanged. Without it -> DECODE->FETCH, trap=0.

Source files
------------

// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the 32-bit MIPS core.
// Sequences PC, IR, memory, register file and datapath mux selects from the
// opcode. Drives ALUOp/ALUOpImmediate into the ALU control decoder. Counts
// retired instructions.
// Optional feature: define ILLEGAL_TRAP_EN to route unknown opcodes to a
// one-cycle TRAP state. Without it, unknown opcodes are a DECODE->FETCH no-op
// and trap is tied low.
module mc_main_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [2:0]         ALUOpImmediate,
  output logic [3:0]         state,
  output logic               trap,
  output logic [COUNT_W-1:0] retired
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSubi = 6'b001001;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpSlti = 6'b001010;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRtypeWb = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StIExec   = 4'd10,
    StIWb     = 4'd11,
    StTrap    = 4'd12
  } state_e;

  state_e             state_q;
  logic [COUNT_W-1:0] retired_q;
  logic [2:0]         imm_op_q;

  // The branch decision is taken in the datapath via PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic logic [2:0] imm_decode(input logic [5:0] op);
    case (op)
      OpAddi:  return 3'b001;
      OpSubi:  return 3'b010;
      OpAndi:  return 3'b011;
      OpOri:   return 3'b100;
      OpSlti:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // State sequencing, retired counter and latched immediate ALU op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
      imm_op_q  <= 3'b000;
    end else begin
      case (state_q)
        StFetch: if (mem_ready) state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpR:        state_q <= StExec;
            OpBeq:      state_q <= StBranch;
            OpJ:        state_q <= StJump;
            OpAddi, OpSubi, OpAndi, OpOri, OpSlti: begin
              state_q  <= StIExec;
              // Latched so ALUOpImmediate stays stable through IEXEC.
              imm_op_q <= imm_decode(opcode);
            end
`ifdef ILLEGAL_TRAP_EN
            default:    state_q <= StTrap;
`else
            default:    state_q <= StFetch;
`endif
          endcase
        end
        StMemAdr: state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd:  if (mem_ready) state_q <= StMemWb;
        StMemWb: begin
          state_q   <= StFetch;
          retired_q <= retired_q + COUNT_W'(1);
        end
        StMemWr: begin
          if (mem_ready) begin
            state_q   <= StFetch;
            retired_q <= retired_q + COUNT_W'(1);
          end
        end
        StExec:   state_q <= StRtypeWb;
        StRtypeWb, StBranch, StJump, StIWb: begin
          state_q   <= StFetch;
          retired_q <= retired_q + COUNT_W'(1);
        end
        StIExec:  state_q <= StIWb;
        // TRAP and unreachable encodings all return to FETCH uncounted.
        default:  state_q <= StFetch;
      endcase
    end
  end

  // Moore decode of controls from state; FETCH IRWrite/PCWrite follow mem_ready.
  // Controls are forced low while reset is asserted, even though state is FETCH.
  always_comb begin
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    MemtoReg       = 1'b0;
    RegDst         = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    PCSource       = 2'b00;
    ALUOp          = 2'b00;
    ALUOpImmediate = 3'b000;
    trap           = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        StDecode: ALUSrcB = 2'b11;
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        StMemWr: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        StRtypeWb: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        StIExec: begin
          ALUSrcA        = 1'b1;
          ALUSrcB        = 2'b10;
          ALUOp          = 2'b11;
          ALUOpImmediate = imm_op_q;
        end
        StIWb: RegWrite = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        StTrap: begin
          trap     = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 2'b11;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
